// File: rtl/branch_resolve_unit_if.sv
// Purpose : bundles the issue group, redirect/link results, BPU update port and perf counters
//           of the branch resolve unit.
// Ports   : slave = resolve unit side, master = issue/BPU/bench side; clk/rst_n stay outside.
interface branch_resolve_unit_if #(
  parameter int LANES  = 2,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic                         flush_i;
  logic [LANES-1:0]             in_valid_i;
  logic                         in_ready_o;
  logic [LANES-1:0][3:0]        br_op_i;
  logic [LANES-1:0][ADDR_W-1:0] pc_i;
  logic [LANES-1:0][ADDR_W-1:0] inst_i;
  logic [LANES-1:0][ADDR_W-1:0] reg1_i;
  logic [LANES-1:0][ADDR_W-1:0] reg2_i;
  logic [LANES-1:0]             pred_taken_i;
  logic [LANES-1:0][ADDR_W-1:0] pred_addr_i;
  logic [LANES-1:0]             link_valid_o;
  logic [LANES-1:0][ADDR_W-1:0] link_res_o;
  logic                         redirect_valid_o;
  logic [ADDR_W-1:0]            redirect_pc_o;
  logic                         upd_valid_o;
  logic                         upd_ready_i;
  logic [ADDR_W-1:0]            upd_pc_o;
  logic [ADDR_W-1:0]            upd_target_o;
  logic                         upd_taken_o;
  logic                         upd_mispred_o;
  logic [CNT_W-1:0]             br_cnt_o;
  logic [CNT_W-1:0]             mispred_cnt_o;

  modport slave (
    input  flush_i, in_valid_i, br_op_i, pc_i, inst_i, reg1_i, reg2_i,
           pred_taken_i, pred_addr_i, upd_ready_i,
    output in_ready_o, link_valid_o, link_res_o, redirect_valid_o, redirect_pc_o,
           upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_mispred_o,
           br_cnt_o, mispred_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, br_op_i, pc_i, inst_i, reg1_i, reg2_i,
           pred_taken_i, pred_addr_i, upd_ready_i,
    input  in_ready_o, link_valid_o, link_res_o, redirect_valid_o, redirect_pc_o,
           upd_valid_o, upd_pc_o, upd_target_o, upd_taken_o, upd_mispred_o,
           br_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Purpose     : resolves up to LANES branch/jump uops per cycle, raises a redirect for the oldest
//               mispredicting lane, queues predictor updates and counts branches/mispredicts.
// Latency     : redirect/link/update visible 1 cycle after acceptance.
// Backpressure: in_ready_o drops unless a full group fits in the update FIFO (registered count);
//               the FIFO drains over upd_valid_o/upd_ready_i.
// Ports       : clk, rst_n (async active-low), bus (branch_resolve_unit_if.slave).
module branch_resolve_unit #(
  parameter int LANES     = 2,
  parameter int ADDR_W    = 32,
  parameter int UPD_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);
  localparam int             PTR_W   = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] RDY_MAX = (PTR_W+1)'(UPD_DEPTH - LANES);

  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_BLT  = 4'd3;
  localparam logic [3:0] OP_BGE  = 4'd4;
  localparam logic [3:0] OP_BLTU = 4'd5;
  localparam logic [3:0] OP_BGEU = 4'd6;
  localparam logic [3:0] OP_B    = 4'd7;
  localparam logic [3:0] OP_BL   = 4'd8;
  localparam logic [3:0] OP_JIRL = 4'd9;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              mispred;
  } upd_t;

  // Per-lane resolution results
  logic [LANES-1:0]  lane_br, lane_link, lane_taken, lane_mis;
  logic [ADDR_W-1:0] lane_tgt [LANES];
  logic [ADDR_W-1:0] lane_npc [LANES];
  logic [ADDR_W-1:0] lane_seq [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ADDR_W-1:0] pc, r1, r2, off16, off26, seq, tgt;
    logic [25:0]       inst;
    logic              eq, lts, ltu, br, link, taken;
    logic              unused_inst_hi;

    assign pc    = bus.pc_i[l];
    assign r1    = bus.reg1_i[l];
    assign r2    = bus.reg2_i[l];
    assign inst  = bus.inst_i[l][25:0];
    assign unused_inst_hi = ^bus.inst_i[l][ADDR_W-1:26];
    assign off16 = {{(ADDR_W-18){inst[25]}}, inst[25:10], 2'b00};
    assign off26 = {{(ADDR_W-28){inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    assign seq   = pc + ADDR_W'(4);
    assign eq    = (r1 == r2);
    assign lts   = ($signed(r1) < $signed(r2));
    assign ltu   = (r1 < r2);

    always_comb begin
      br    = 1'b1;
      link  = 1'b0;
      taken = 1'b0;
      tgt   = pc + off16;
      case (bus.br_op_i[l])
        OP_BEQ:  taken = eq;
        OP_BNE:  taken = ~eq;
        OP_BLT:  taken = lts;
        OP_BGE:  taken = ~lts;
        OP_BLTU: taken = ltu;
        OP_BGEU: taken = ~ltu;
        OP_B:    begin taken = 1'b1; tgt = pc + off26; end
        OP_BL:   begin taken = 1'b1; tgt = pc + off26; link = 1'b1; end
        OP_JIRL: begin taken = 1'b1; tgt = r1 + off16; link = 1'b1; end
        default: br = 1'b0;
      endcase
    end

    assign lane_br[l]    = br;
    assign lane_link[l]  = link;
    assign lane_taken[l] = taken;
    assign lane_tgt[l]   = tgt;
    assign lane_seq[l]   = seq;
    assign lane_npc[l]   = taken ? tgt : seq;
    // A correct direction can still be a mispredict if the predicted target was wrong.
    assign lane_mis[l]   = br & ((taken != bus.pred_taken_i[l]) |
                                 (taken & bus.pred_taken_i[l] & (bus.pred_addr_i[l] != tgt)));
  end

  // State
  logic                    redirect_q;
  logic [ADDR_W-1:0]       redirect_pc_q;
  logic [LANES-1:0]        link_vld_q;
  logic [ADDR_W-1:0]       link_res_q [LANES];
  upd_t                    mem [UPD_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count;
  logic [CNT_W-1:0]        br_cnt_q, mis_cnt_q;

  logic                    in_ready, accept, deq, upd_vld;
  logic [LANES-1:0]        live, surv, enq;
  logic [PTR_W-1:0]        slot [LANES];
  logic [PTR_W:0]          n_enq;
  logic                    win_vld, killed;
  logic [ADDR_W-1:0]       win_pc;
  logic [CNT_W:0]          br_sum, mis_sum;

  // Credit is taken from the registered count only; a same-cycle dequeue does not help.
  assign in_ready = (count <= RDY_MAX);
  // Inputs arriving while our own redirect is visible are wrong-path.
  assign accept   = in_ready & ~bus.flush_i & ~redirect_q;
  assign live     = bus.in_valid_i & {LANES{accept}};
  assign upd_vld  = (count != '0);
  assign deq      = upd_vld & bus.upd_ready_i;

  // Oldest mispredicting lane wins; everything younger is squashed. Surviving
  // branch lanes are packed into consecutive FIFO slots in lane order.
  always_comb begin
    killed  = 1'b0;
    win_vld = 1'b0;
    win_pc  = '0;
    n_enq   = '0;
    surv    = '0;
    enq     = '0;
    for (int l = 0; l < LANES; l++) begin
      slot[l] = n_enq[PTR_W-1:0];
      surv[l] = live[l] & ~killed;
      enq[l]  = surv[l] & lane_br[l];
      if (enq[l]) n_enq = n_enq + ONE;
      if (enq[l] & lane_mis[l]) begin
        win_vld = 1'b1;
        win_pc  = lane_npc[l];
        killed  = 1'b1;
      end
    end
  end

  assign br_sum  = {1'b0, br_cnt_q} + (CNT_W+1)'(n_enq);
  assign mis_sum = {1'b0, mis_cnt_q} + (CNT_W+1)'(win_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_vld_q    <= '0;
      for (int l = 0; l < LANES; l++) link_res_q[l] <= '0;
      for (int i = 0; i < UPD_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redirect_q    <= win_vld;
      redirect_pc_q <= win_pc;
      for (int l = 0; l < LANES; l++) begin
        link_vld_q[l] <= surv[l] & lane_link[l];
        link_res_q[l] <= (surv[l] & lane_link[l]) ? lane_seq[l] : '0;
        if (enq[l]) begin
          mem[wr_ptr + slot[l]] <= {bus.pc_i[l], lane_tgt[l], lane_taken[l], lane_mis[l]};
        end
      end
      wr_ptr    <= wr_ptr + n_enq[PTR_W-1:0];
      rd_ptr    <= rd_ptr + PTR_W'(deq);
      count     <= count + n_enq - {{PTR_W{1'b0}}, deq};
      br_cnt_q  <= br_sum[CNT_W]  ? '1 : br_sum[CNT_W-1:0];
      mis_cnt_q <= mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
    end
  end

  assign bus.in_ready_o       = in_ready;
  assign bus.redirect_valid_o = redirect_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
  assign bus.link_valid_o     = link_vld_q;
  for (genvar l = 0; l < LANES; l++) begin : g_link_out
    assign bus.link_res_o[l] = link_res_q[l];
  end
  assign bus.upd_valid_o      = upd_vld;
  assign bus.upd_pc_o         = mem[rd_ptr].pc;
  assign bus.upd_target_o     = mem[rd_ptr].target;
  assign bus.upd_taken_o      = mem[rd_ptr].taken;
  assign bus.upd_mispred_o    = mem[rd_ptr].mispred;
  assign bus.br_cnt_o         = br_cnt_q;
  assign bus.mispred_cnt_o    = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose : self-checking bench for branch_resolve_unit: directed scenarios then random traffic
//           against a queue-based reference model.
// Ports   : none; drives the DUT through a branch_resolve_unit_if instance.
module tb_branch_resolve_unit;
  localparam int LANES = 2, ADDR_W = 32, UPD_DEPTH = 4, CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.LANES(LANES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.LANES(LANES), .ADDR_W(ADDR_W), .UPD_DEPTH(UPD_DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        mis;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  bit          m_redir;
  logic [31:0] m_redir_pc;
  bit   [1:0]  m_link;
  logic [31:0] m_link_res [LANES];
  logic [31:0] m_br, m_mis;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk16(input logic [15:0] imm);
    return {6'b0, imm, 10'b0};
  endfunction

  // Architectural meaning of each op, in plain integer arithmetic.
  function automatic void ref_eval(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] inst,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   output bit br, output bit lnk, output bit tk, output logic [31:0] tgt);
    int          s16, s26;
    logic [25:0] f26;
    s16 = int'($signed(inst[25:10]));
    f26 = {inst[9:0], inst[25:10]};
    s26 = int'($signed(f26));
    br  = 1; lnk = 0; tk = 0;
    tgt = pc + 32'(s16 * 4);
    case (op)
      4'd1: tk = (r1 == r2);
      4'd2: tk = (r1 != r2);
      4'd3: tk = ($signed(r1) <  $signed(r2));
      4'd4: tk = ($signed(r1) >= $signed(r2));
      4'd5: tk = (r1 <  r2);
      4'd6: tk = (r1 >= r2);
      4'd7: begin tk = 1; tgt = pc + 32'(s26 * 4); end
      4'd8: begin tk = 1; lnk = 1; tgt = pc + 32'(s26 * 4); end
      4'd9: begin tk = 1; lnk = 1; tgt = r1 + 32'(s16 * 4); end
      default: br = 0;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_redir = 0; m_redir_pc = '0; m_link = '0;
    m_br = '0; m_mis = '0;
    for (int l = 0; l < LANES; l++) m_link_res[l] = '0;
  endtask

  task automatic model_cycle();
    bit          acc, killed, br, lnk, tk, mis;
    logic [31:0] tgt, npc, pc;
    acc = (q.size() <= UPD_DEPTH - LANES) && !bus.flush_i && !m_redir;
    if (q.size() != 0 && bus.upd_ready_i) void'(q.pop_front());
    m_redir = 0; m_link = '0; killed = 0;
    for (int l = 0; l < LANES; l++) begin
      if (acc && bus.in_valid_i[l] && !killed) begin
        pc = bus.pc_i[l];
        ref_eval(bus.br_op_i[l], pc, bus.inst_i[l], bus.reg1_i[l], bus.reg2_i[l], br, lnk, tk, tgt);
        if (br) begin
          npc = tk ? tgt : pc + 32'd4;
          mis = (tk != bus.pred_taken_i[l]) || (tk && bus.pred_taken_i[l] && bus.pred_addr_i[l] != tgt);
          q.push_back('{pc: pc, tgt: tgt, taken: tk, mis: mis});
          m_br = m_br + 1;
          if (lnk) begin m_link[l] = 1; m_link_res[l] = pc + 32'd4; end
          if (mis) begin m_redir = 1; m_redir_pc = npc; m_mis = m_mis + 1; killed = 1; end
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("redir_v", 64'(bus.redirect_valid_o), 64'(m_redir));
    if (m_redir) check_eq("redir_pc", 64'(bus.redirect_pc_o), 64'(m_redir_pc));
    for (int l = 0; l < LANES; l++) begin
      check_eq($sformatf("link_v%0d", l), 64'(bus.link_valid_o[l]), 64'(m_link[l]));
      if (m_link[l]) check_eq($sformatf("link_res%0d", l), 64'(bus.link_res_o[l]), 64'(m_link_res[l]));
    end
    check_eq("upd_v", 64'(bus.upd_valid_o), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("upd_pc",  64'(bus.upd_pc_o),      64'(q[0].pc));
      check_eq("upd_tgt", 64'(bus.upd_target_o),  64'(q[0].tgt));
      check_eq("upd_tk",  64'(bus.upd_taken_o),   64'(q[0].taken));
      check_eq("upd_mis", 64'(bus.upd_mispred_o), 64'(q[0].mis));
    end
    check_eq("in_rdy",  64'(bus.in_ready_o),    64'(q.size() <= UPD_DEPTH - LANES));
    check_eq("br_cnt",  64'(bus.br_cnt_o),      64'(m_br));
    check_eq("mis_cnt", 64'(bus.mispred_cnt_o), 64'(m_mis));
  endtask

  // One clock: model consumes the driven inputs, then outputs are sampled 1ns after the edge.
  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    bus.in_valid_i = '0; bus.br_op_i = '0; bus.pc_i = '0; bus.inst_i = '0;
    bus.reg1_i = '0; bus.reg2_i = '0; bus.pred_taken_i = '0; bus.pred_addr_i = '0;
  endtask

  task automatic set_lane(input int l, input logic [3:0] op, input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] r1, input logic [31:0] r2, input logic pt, input logic [31:0] pa);
    bus.in_valid_i[l] = 1'b1; bus.br_op_i[l] = op; bus.pc_i[l] = pc; bus.inst_i[l] = inst;
    bus.reg1_i[l] = r1; bus.reg2_i[l] = r2; bus.pred_taken_i[l] = pt; bus.pred_addr_i[l] = pa;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_redir"},  64'(bus.redirect_valid_o), 64'd0);
    check_eq({pfx, "_link"},   64'(bus.link_valid_o),     64'd0);
    check_eq({pfx, "_upd_v"},  64'(bus.upd_valid_o),      64'd0);
    check_eq({pfx, "_upd_pc"}, 64'(bus.upd_pc_o),         64'd0);
    check_eq({pfx, "_br"},     64'(bus.br_cnt_o),         64'd0);
    check_eq({pfx, "_mis"},    64'(bus.mispred_cnt_o),    64'd0);
    check_eq({pfx, "_rdy"},    64'(bus.in_ready_o),       64'd1);
  endtask

  initial begin
    logic [31:0] br_before, mis_before, r1, r2, pc, inst, tgt;
    logic [3:0]  op;
    bit          br, lnk, tk;

    clear_in();
    bus.flush_i = 1'b0;
    bus.upd_ready_i = 1'b1;
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Correctly predicted taken BEQ
    set_lane(0, 4'd1, 32'h1C000000, mk16(16'd4), 32'd5, 32'd5, 1'b1, 32'h1C000010);
    step();
    check_eq("t1_redir", 64'(bus.redirect_valid_o), 64'd0);
    check_eq("t1_tgt",   64'(bus.upd_target_o),     64'h1C000010);
    check_eq("t1_tk",    64'(bus.upd_taken_o),      64'd1);
    check_eq("t1_mis",   64'(bus.upd_mispred_o),    64'd0);
    check_eq("t1_br",    64'(bus.br_cnt_o),         64'd1);
    clear_in(); step();

    // Signed BLT mispredict squashes younger BL
    set_lane(0, 4'd3, 32'h1C000100, mk16(16'd8), 32'hFFFFFFFF, 32'd1, 1'b0, 32'h0);
    set_lane(1, 4'd8, 32'h1C000104, mk16(16'd4), 32'd0, 32'd0, 1'b1, 32'h1C000114);
    step();
    check_eq("t2_redir", 64'(bus.redirect_valid_o), 64'd1);
    check_eq("t2_pc",    64'(bus.redirect_pc_o),    64'h1C000120);
    check_eq("t2_link1", 64'(bus.link_valid_o[1]),  64'd0);
    check_eq("t2_mis",   64'(bus.mispred_cnt_o),    64'd1);
    check_eq("t2_upd",   64'(bus.upd_pc_o),         64'h1C000100);
    step();  // same group still presented while redirect visible: wrong path
    check_eq("t2_ign_redir", 64'(bus.redirect_valid_o), 64'd0);
    check_eq("t2_ign_br",    64'(bus.br_cnt_o),         64'd2);
    clear_in(); step();

    // Unsigned BLTU not taken against taken prediction
    set_lane(0, 4'd5, 32'h1C000200, mk16(16'd4), 32'hFFFFFFFF, 32'd1, 1'b1, 32'h1C000210);
    step();
    check_eq("t3_pc",  64'(bus.redirect_pc_o), 64'h1C000204);
    check_eq("t3_tk",  64'(bus.upd_taken_o),   64'd0);
    check_eq("t3_mis", 64'(bus.upd_mispred_o), 64'd1);
    clear_in(); step();

    // JIRL with wrong predicted target
    set_lane(0, 4'd9, 32'h1C000300, mk16(16'd2), 32'h1C001000, 32'd0, 1'b1, 32'h1C001000);
    step();
    check_eq("t4_pc",   64'(bus.redirect_pc_o),   64'h1C001008);
    check_eq("t4_lv",   64'(bus.link_valid_o[0]), 64'd1);
    check_eq("t4_lres", 64'(bus.link_res_o[0]),   64'h1C000304);
    clear_in(); step(); step();

    // FIFO fill under backpressure, then drain in order
    bus.upd_ready_i = 1'b0;
    set_lane(0, 4'd2, 32'h1C000400, mk16(16'd4), 32'd7, 32'd7, 1'b0, 32'h0);
    set_lane(1, 4'd2, 32'h1C000404, mk16(16'd4), 32'd7, 32'd7, 1'b0, 32'h0);
    step();
    bus.pc_i[0] = 32'h1C000408; bus.pc_i[1] = 32'h1C00040C;
    step();
    check_eq("t5_rdy0", 64'(bus.in_ready_o), 64'd0);
    check_eq("t5_head", 64'(bus.upd_pc_o),   64'h1C000400);
    step();
    check_eq("t5_hold", 64'(bus.upd_pc_o),   64'h1C000400);
    bus.upd_ready_i = 1'b1;
    step();
    check_eq("t5_rdy1", 64'(bus.in_ready_o), 64'd0);
    clear_in(); step();
    check_eq("t5_order", 64'(bus.upd_pc_o),  64'h1C000408);
    step(); step();

    // Flush kills a mispredicting lane 0
    br_before = m_br; mis_before = m_mis;
    set_lane(0, 4'd1, 32'h1C000500, mk16(16'd4), 32'd1, 32'd2, 1'b1, 32'h1C000510);
    bus.flush_i = 1'b1;
    step();
    check_eq("t6_redir", 64'(bus.redirect_valid_o), 64'd0);
    check_eq("t6_upd_v", 64'(bus.upd_valid_o),      64'd0);
    check_eq("t6_br",    64'(bus.br_cnt_o),         64'(br_before));
    check_eq("t6_mis",   64'(bus.mispred_cnt_o),    64'(mis_before));
    bus.flush_i = 1'b0; clear_in(); step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.flush_i     = ($urandom_range(15) == 0);
      bus.upd_ready_i = ($urandom_range(3) != 0);
      for (int l = 0; l < LANES; l++) begin
        op   = 4'($urandom_range(11));
        pc   = $urandom() & 32'hFFFFFFFC;
        inst = $urandom();
        r1   = ($urandom_range(1) == 0) ? $urandom() : 32'($urandom_range(8)) - 32'd4;
        r2   = ($urandom_range(3) == 0) ? r1 : 32'($urandom_range(8)) - 32'd4;
        ref_eval(op, pc, inst, r1, r2, br, lnk, tk, tgt);
        set_lane(l, op, pc, inst, r1, r2, 1'($urandom_range(1)),
                 ($urandom_range(3) != 0) ? tgt : $urandom());
        bus.in_valid_i[l] = ($urandom_range(3) != 0);
      end
      step();
    end

    // Asynchronous reset in the middle of a drain
    bus.flush_i = 1'b0; bus.upd_ready_i = 1'b0; clear_in(); step(); step();
    set_lane(0, 4'd2, 32'h1C000600, mk16(16'd4), 32'd3, 32'd3, 1'b0, 32'h0);
    set_lane(1, 4'd2, 32'h1C000604, mk16(16'd4), 32'd3, 32'd3, 1'b0, 32'h0);
    step();
    bus.upd_ready_i = 1'b1; clear_in(); step();
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_lane(0, 4'd7, 32'h1C000700, 32'h0, 32'd0, 32'd0, 1'b1, 32'h1C000700);
    step();
    clear_in(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
